// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the ram_port_ctrl front end.
//                - ram_ctrl_state_e : controller states (IDLE, MERGE)
//                - STRB_W           : byte-strobe width for the default word
//                - ram_rsp_t        : response FIFO entry {write, data}
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int RAM_DATAWIDTH = 32;
  localparam int RAM_ADDRWIDTH = 16;
  localparam int STRB_W        = RAM_DATAWIDTH / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } ram_ctrl_state_e;

  typedef struct packed {
    logic                     write;
    logic [RAM_DATAWIDTH-1:0] data;
  } ram_rsp_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rsp_fifo
//  Description : Synchronous FIFO holding responses for ram_port_ctrl.
//                Simultaneous push and pop leave the count unchanged.
//  Ports       : clk      - clock
//                rst      - asynchronous active-high reset (FIFO empty)
//                i_push   - write i_data at the tail
//                i_data   - entry to write
//                i_pop    - drop the head entry (ignored when empty)
//                o_data   - head entry (undefined when o_valid is low)
//                o_valid  - FIFO holds at least one entry
//                o_count  - number of entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int WIDTH = RAM_DATAWIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int                   c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]     c_FULL  = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit scheme must never let a push meet a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && i_push) begin
      assert (!w_full);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule : ram_rsp_fifo
`default_nettype wire

// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_ctrl
//  Description : Request front end for the single-port ram macro. Reads and
//                full-strobe writes go straight to the RAM; partial writes
//                become a read followed by a merged write. Every request
//                produces one in-order response through ram_rsp_fifo, with
//                ReqReady issued only when a FIFO slot is guaranteed.
//  Ports       : PortAClk/PortAReset    - clock, async active-high reset
//                ReqValid/ReqReady      - request handshake
//                ReqWrite/Addr/Data/Strb- request payload
//                RspValid/RspReady      - response handshake
//                RspWrite/RspData       - response payload (data 0 on writes)
//                RamAddr/RamDataIn/RamWriteEnable/RamDataOut - RAM pins
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_ctrl
  import ram_pkg::*;
#(
  parameter int DATAWIDTH = RAM_DATAWIDTH,
  parameter int ADDRWIDTH = RAM_ADDRWIDTH,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   PortAClk,
  input  logic                   PortAReset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [ADDRWIDTH-1:0]   ReqAddr,
  input  logic [DATAWIDTH-1:0]   ReqData,
  input  logic [DATAWIDTH/8-1:0] ReqStrb,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic                   RspWrite,
  output logic [DATAWIDTH-1:0]   RspData,
  output logic [ADDRWIDTH-1:0]   RamAddr,
  output logic [DATAWIDTH-1:0]   RamDataIn,
  output logic                   RamWriteEnable,
  input  logic [DATAWIDTH-1:0]   RamDataOut
);

  localparam int               c_STRB_W     = DATAWIDTH / 8;
  localparam int               c_CNT_W      = $clog2(RSP_DEPTH) + 1;
  localparam logic [c_CNT_W:0] c_CREDIT_LIM = (c_CNT_W+1)'(RSP_DEPTH);
  localparam logic [0:0]       c_ST_IDLE    = IDLE;
  localparam logic [0:0]       c_ST_MERGE   = MERGE;

  logic [0:0]           r_state;
  logic [ADDRWIDTH-1:0] r_cap_addr;
  logic [DATAWIDTH-1:0] r_cap_data;
  logic [c_STRB_W-1:0]  r_cap_strb;
  logic                 r_pend_valid;
  logic                 r_pend_write;

  logic [c_CNT_W-1:0]   w_fifo_count;
  logic                 w_fifo_valid;
  logic [DATAWIDTH:0]   w_fifo_head;
  logic [DATAWIDTH:0]   w_push_data;
  logic [c_CNT_W:0]     w_credit_used;
  logic                 w_has_credit;
  logic                 w_in_merge;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_full_strb;
  logic [DATAWIDTH-1:0] w_merged;

  // A slot is reserved for the response still sitting in the pend stage, so
  // the push one cycle later always finds room.
  assign w_credit_used = {1'b0, w_fifo_count} + {{c_CNT_W{1'b0}}, r_pend_valid};
  assign w_has_credit  = (w_credit_used < c_CREDIT_LIM);
  assign w_in_merge    = (r_state == c_ST_MERGE);
  assign w_req_ready   = !PortAReset && !w_in_merge && w_has_credit;
  assign w_accept      = ReqValid && w_req_ready;
  assign w_full_strb   = &ReqStrb;

  // Byte merge of the captured write data over the old word read last cycle.
  generate
    for (genvar gi = 0; gi < c_STRB_W; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = r_cap_strb[gi] ? r_cap_data[8*gi +: 8]
                                                  : RamDataOut[8*gi +: 8];
    end
  endgenerate

  // In IDLE the RAM pins follow the request directly so an accepted access
  // is performed in its accept cycle.
  always_comb begin
    RamAddr        = ReqAddr;
    RamDataIn      = ReqData;
    RamWriteEnable = w_accept && ReqWrite && w_full_strb;
    if (w_in_merge) begin
      RamAddr        = r_cap_addr;
      RamDataIn      = w_merged;
      RamWriteEnable = !PortAReset;
    end
  end

  always_ff @(posedge PortAClk or posedge PortAReset) begin
    if (PortAReset) begin
      r_state      <= c_ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_cap_addr   <= '0;
      r_cap_data   <= '0;
      r_cap_strb   <= '0;
    end else begin
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            if (!ReqWrite || w_full_strb) begin
              r_pend_valid <= 1'b1;
              r_pend_write <= ReqWrite;
            end else begin
              // Partial (or empty) strobe: the old word is being read now.
              r_cap_addr <= ReqAddr;
              r_cap_data <= ReqData;
              r_cap_strb <= ReqStrb;
              r_state    <= c_ST_MERGE;
            end
          end
        end
        c_ST_MERGE: begin
          r_pend_valid <= 1'b1;
          r_pend_write <= 1'b1;
          r_state      <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // The pend stage lines up with the RAM's registered read data, so reads
  // and writes share a single push path and stay in order.
  assign w_push_data = {r_pend_write, (r_pend_write ? {DATAWIDTH{1'b0}} : RamDataOut)};

  ram_rsp_fifo #(
    .WIDTH (DATAWIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (PortAClk),
    .rst     (PortAReset),
    .i_push  (r_pend_valid),
    .i_data  (w_push_data),
    .i_pop   (RspReady),
    .o_data  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign ReqReady = w_req_ready;
  assign RspValid = w_fifo_valid;
  // Head storage is not reset, so the payload is masked while empty.
  assign RspWrite = w_fifo_valid && w_fifo_head[DATAWIDTH];
  assign RspData  = w_fifo_valid ? w_fifo_head[DATAWIDTH-1:0] : '0;

endmodule : ram_port_ctrl
`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_ctrl
//  Description : Self-checking bench for ram_port_ctrl with a behavioural
//                RAM beside the DUT and an in-order response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          PortAClk   = 1'b0;
  logic          PortAReset = 1'b1;
  logic          ReqValid   = 1'b0;
  logic          ReqReady;
  logic          ReqWrite   = 1'b0;
  logic [AW-1:0] ReqAddr    = '0;
  logic [DW-1:0] ReqData    = '0;
  logic [3:0]    ReqStrb    = '0;
  logic          RspValid;
  logic          RspReady;
  logic          RspWrite;
  logic [DW-1:0] RspData;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataIn;
  logic          RamWriteEnable;
  logic [DW-1:0] RamDataOut;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_rsp  = 0;

  logic rsp_rand_en  = 1'b0;
  logic rsp_force    = 1'b1;
  logic r_rand_ready = 1'b1;
  assign RspReady = rsp_rand_en ? r_rand_ready : rsp_force;

  ram_port_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .PortAClk       (PortAClk),
    .PortAReset     (PortAReset),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .ReqWrite       (ReqWrite),
    .ReqAddr        (ReqAddr),
    .ReqData        (ReqData),
    .ReqStrb        (ReqStrb),
    .RspValid       (RspValid),
    .RspReady       (RspReady),
    .RspWrite       (RspWrite),
    .RspData        (RspData),
    .RamAddr        (RamAddr),
    .RamDataIn      (RamDataIn),
    .RamWriteEnable (RamWriteEnable),
    .RamDataOut     (RamDataOut)
  );

  always #5 PortAClk = ~PortAClk;
  always @(posedge PortAClk) cyc <= cyc + 1;
  always @(posedge PortAClk) r_rand_ready <= ($urandom_range(0, 3) != 0);

  // Single-port RAM with registered read, contents kept across reset.
  logic [DW-1:0] mem [0:65535];
  always @(posedge PortAClk) begin
    if (RamWriteEnable) mem[RamAddr] <= RamDataIn;
    RamDataOut <= mem[RamAddr];
  end

  // Reference model: word memory plus expected-response queue.
  typedef struct { logic w; logic [DW-1:0] d; } exp_t;
  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] ref_mem [0:65535];
  int            rsp_cyc_log [0:1023];
  logic          pp_valid = 1'b0;
  logic [AW-1:0] pp_addr;
  logic [DW-1:0] pp_data;
  logic [3:0]    pp_strb;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [3:0]    strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge PortAClk) begin
    if (PortAReset) begin
      exp_q.delete();
      pp_valid = 1'b0;
    end else begin
      // A partial write lands one cycle after acceptance unless reset hits.
      if (pp_valid) begin
        ref_mem[pp_addr] = apply_strb(ref_mem[pp_addr], pp_data, pp_strb);
        exp_q.push_back('{w: 1'b1, d: '0});
        pp_valid = 1'b0;
      end
      if (RspValid && RspReady) begin
        rsp_cyc_log[n_rsp % 1024] = cyc;
        n_rsp++;
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_write", RspWrite, e.w);
          check("rsp_data", RspData, e.d);
        end
      end
      if (ReqValid && ReqReady) begin
        n_acc++;
        if (!ReqWrite) begin
          exp_q.push_back('{w: 1'b0, d: ref_mem[ReqAddr]});
        end else if (ReqStrb == 4'hF) begin
          ref_mem[ReqAddr] = ReqData;
          exp_q.push_back('{w: 1'b1, d: '0});
        end else begin
          pp_valid = 1'b1;
          pp_addr  = ReqAddr;
          pp_data  = ReqData;
          pp_strb  = ReqStrb;
        end
      end
    end
  end

  // Starts and ends just after a rising edge; returns the accept cycle.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, output int acc_c, output int waited);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d; ReqStrb = s;
    waited = 0;
    @(negedge PortAClk);
    while (!ReqReady && waited < 64) begin
      @(negedge PortAClk);
      waited++;
    end
    if (!ReqReady) check("issue_accept", ReqReady, 1);
    acc_c = cyc;
    @(posedge PortAClk); #1;
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pp_valid || RspValid) && n < 300) begin
      @(posedge PortAClk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic step();
    @(posedge PortAClk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wt, acc0, base, issued, n;
    logic [DW-1:0] old9;

    // Reset: a full write presented during reset must not reach the RAM.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'd3; ReqData = 32'hFFFF_0000; ReqStrb = 4'hF;
    repeat (2) @(posedge PortAClk);
    @(negedge PortAClk);
    check("rst_req_ready", ReqReady, 0);
    check("rst_we", RamWriteEnable, 0);
    check("rst_rsp_valid", RspValid, 0);
    check("rst_rsp_write", RspWrite, 0);
    check("rst_rsp_data", RspData, 0);
    ReqValid = 1'b0;
    step();
    PortAReset = 1'b0;
    @(negedge PortAClk);
    check("post_rst_ready", ReqReady, 1);
    step();

    // Preload words 0..15 through full writes.
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] v;
      v = (i < 4) ? 32'h1111_1111 * (i + 1) : (i == 7) ? 32'hAABB_CCDD : $urandom;
      issue(1'b1, AW'(i), v, 4'hF, acc, wt);
    end
    drain();

    // Single read latency: RspValid at accept+2.
    issue(1'b0, 16'd1, '0, 4'h0, acc, wt);
    @(negedge PortAClk); check("rd_lat_n1", RspValid, 0);
    step(); @(negedge PortAClk); check("rd_lat_n2", RspValid, 1);
    step(); drain();

    // Back-to-back reads 0..3.
    base = n_rsp;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, AW'(i), '0, 4'h0, acc, wt);
      if (i == 0) acc0 = acc;
      check("b2b_no_wait", wt, 0);
      check("b2b_acc_cycle", acc, acc0 + i);
    end
    drain();
    check("b2b_rsp_count", n_rsp - base, 4);
    for (int i = 0; i < 4; i++) check("b2b_rsp_cycle", rsp_cyc_log[(base + i) % 1024], acc0 + 2 + i);

    // Full write then immediate read of the same word.
    issue(1'b1, 16'd5, 32'hDEAD_BEEF, 4'hF, acc, wt);
    @(negedge PortAClk); check("wr_lat_n1", RspValid, 0);
    issue(1'b0, 16'd5, '0, 4'h0, acc, wt);
    drain();
    check("wr_mem5", mem[5], 32'hDEAD_BEEF);

    // Partial write: read-modify-write on word 7.
    issue(1'b1, 16'd7, 32'h1122_3344, 4'h5, acc, wt);
    @(negedge PortAClk);
    check("rmw_ready_low", ReqReady, 0);
    check("rmw_we", RamWriteEnable, 1);
    check("rmw_addr", RamAddr, 7);
    check("rmw_merged", RamDataIn, 32'hAA22_CC44);
    step(); @(negedge PortAClk);
    check("rmw_ready_back", ReqReady, 1);
    check("rmw_lat_n2", RspValid, 0);
    step(); @(negedge PortAClk);
    check("rmw_lat_n3", RspValid, 1);
    step(); drain();
    check("rmw_mem7", mem[7], 32'hAA22_CC44);

    // Zero strobe rewrites the word unchanged.
    issue(1'b1, 16'd2, 32'h1234_5678, 4'hF, acc, wt);
    base = n_rsp;
    issue(1'b1, 16'd2, 32'hFFFF_FFFF, 4'h0, acc, wt);
    @(negedge PortAClk);
    check("zs_we", RamWriteEnable, 1);
    check("zs_data", RamDataIn, 32'h1234_5678);
    step(); drain();
    check("zs_rsp_count", n_rsp - base, 2);
    check("zs_mem2", mem[2], 32'h1234_5678);

    // Backpressure: with RspReady low exactly DEPTH reads are taken.
    rsp_force = 1'b0;
    issued = 0;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = AW'($urandom_range(0, 15));
    for (int c = 0; c < 12; c++) begin
      @(negedge PortAClk);
      if (ReqValid && ReqReady) issued++;
      step();
      if (issued != 0) ReqAddr = AW'($urandom_range(0, 15));
    end
    @(negedge PortAClk);
    check("bp_accepted", issued, DEPTH);
    check("bp_ready_low", ReqReady, 0);
    check("bp_rsp_valid", RspValid, 1);
    step();
    rsp_force = 1'b1;
    n = 0;
    while (issued < 8 && n < 64) begin
      @(negedge PortAClk);
      if (ReqValid && ReqReady) issued++;
      step();
      ReqAddr = AW'($urandom_range(0, 15));
      if (issued >= 8) ReqValid = 1'b0;
      n++;
    end
    ReqValid = 1'b0;
    check("bp_total_accepted", issued, 8);
    drain();

    // Reset asserted in the merge cycle drops the partial write.
    old9 = ref_mem[9];
    issue(1'b1, 16'd9, ~old9, 4'h3, acc, wt);
    PortAReset = 1'b1;
    #1;
    check("rstm_we", RamWriteEnable, 0);
    @(negedge PortAClk);
    check("rstm_rsp_valid", RspValid, 0);
    check("rstm_ready", ReqReady, 0);
    step(); step();
    PortAReset = 1'b0;
    @(negedge PortAClk);
    check("rstm_ready_after", ReqReady, 1);
    check("rstm_mem9", mem[9], old9);
    step();
    issue(1'b0, 16'd9, '0, 4'h0, acc, wt);
    drain();

    // Random mix with random response backpressure.
    rsp_rand_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [3:0] s;
      int sel;
      sel = $urandom_range(0, 3);
      s = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, s, acc, wt);
      if ($urandom_range(0, 4) == 0) step();
    end
    rsp_rand_en = 1'b0;
    drain();

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
    check("final_rsp_valid", RspValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ram_port_ctrl
`default_nettype wire
